e_mdu: RTL
==========

// Module: e_mdu
// PURPOSE
//   Multiply/divide unit in the E stage of the 5-stage MIPS pipeline; its HI/LO read data feeds the E->M register via the E-stage result mux.
//   Executes mult/multu/div/divu with fixed multi-cycle latency and holds the architectural HI/LO registers.
//   Exports busy so the D-stage hazard unit can stall later HI/LO users.
//   Honours the exception flush so a cancelled instruction never alters HI/LO.
// PARAMETERS
//   MULT_CYCLES  5   cycles busy stays high after a mult/multu start (>=1)
//   DIV_CYCLES   10  cycles busy stays high after a div/divu start (>=1)
//   CNT_W        4   counter width; must hold max(MULT_CYCLES,DIV_CYCLES)
// PORTS
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous, active-high
//   start  in   1   E-stage instr is mult/multu/div/divu, valid this cycle
//   op     in   2   MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3
//   mthi   in   1   E-stage instr is mthi
//   mtlo   in   1   E-stage instr is mtlo
//   flush  in   1   exception/interrupt taken this cycle; cancels the E-stage instr
//   a      in   32  rs operand (forwarded)
//   b      in   32  rt operand (forwarded)
//   busy   out  1   operation in flight
//   hi     out  32  architectural HI
//   lo     out  32  architectural LO
// BEHAVIOUR
//   - reset: busy=0, hi=0, lo=0, cnt=0, pending result cleared; aborts any op in flight, nothing committed.
//   - Accept at edge T when start & !flush & !busy: compute 64-bit result into pend_hi/pend_lo,
//     load cnt = MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3), busy=1 from T.
//   - Each edge with busy=1: cnt<=cnt-1. At edge where cnt==1: hi<=pend_hi, lo<=pend_lo, busy<=0.
//     Net: busy high for exactly N cycles; new HI/LO visible in the same cycle busy falls.
//   - mult: signed 32x32->64, {hi,lo}=a*b. multu: unsigned.
//   - div: lo=signed quotient, hi=signed remainder (C truncation; remainder sign follows a).
//     divu: unsigned. b==0: busy runs full DIV_CYCLES, HI/LO left unchanged.
//   - start while busy: ignored (hazard unit guarantees it does not occur; no queueing).
//   - flush: blocks start, mthi, mtlo in the same cycle. Never affects an op already accepted
//     (that instr has left E and must complete).
//   - mthi/mtlo & !flush & !busy: hi<=a / lo<=a at next edge. While busy: ignored (stalled upstream).
//   - hi/lo outputs always show committed values; pend_* never visible.
//   - Stall rule for hazard unit (external): stall D when D-instr uses MDU and (start | busy).
// STRUCTURE
//   - Shared pipeline constants header/package: MDU_MULT/MULTU/DIV/DIVU op codes, default cycle counts.
//   - Single module; no sub-module. Use built-in * and / / % (signed via $signed); no iterative divider.
//   - Counter + busy + pend registers + HI/LO registers, one always block per register group.
// TESTING
//   - mult a=0xFFFFFFFD(-3) b=5 -> busy 5 cycles; then hi=0xFFFFFFFF lo=0xFFFFFFF1.
//   - multu a=0xFFFFFFFF b=2 -> after 5 cycles hi=0x00000001 lo=0xFFFFFFFE.
//   - div a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD hi=0xFFFFFFFF; divu 7/2 -> lo=3 hi=1.
//   - div with b=0 after hi=0x11,lo=0x22 -> busy 10 cycles, hi=0x11 lo=0x22 unchanged.
//   - start+flush same cycle (mult 3*4) -> busy stays 0, HI/LO unchanged; mtlo a=0x55 with flush -> lo unchanged.
//   - reset asserted at cycle 3 of a div -> next cycle busy=0 hi=0 lo=0; later mthi a=0xABCD -> hi=0xABCD.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared E-stage MDU constants: operation codes and default latencies.
package e_mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;
  localparam int unsigned DATA_W          = 32;

endpackage

// File: rtl/e_mdu_if.sv
// E-stage to MDU request bus plus the HI/LO/busy view returned to the pipeline.
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic              start;
  mdu_op_e           op;
  logic              mthi;
  logic              mtlo;
  logic              flush;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, mthi, mtlo, flush, a, b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, mthi, mtlo, flush, a, b,
    output busy, hi, lo
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div with architectural HI/LO.
// The result is computed at accept time and held privately until the counter expires.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);

  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic [DATA_W-1:0] pend_hi_q;
  logic [DATA_W-1:0] pend_lo_q;
  logic              pend_ok_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic              accept_c;
  logic              is_div_c;
  logic              div_zero_c;
  logic              commit_c;
  logic              wr_hi_c;
  logic              wr_lo_c;
  logic signed [63:0] sa_c, sb_c, sb_safe_c;
  logic        [63:0] ua_c, ub_c, ub_safe_c;
  logic        [63:0] res_c;

  assign accept_c   = bus.start & ~bus.flush & ~busy_q;
  assign is_div_c   = (bus.op == MDU_DIV) | (bus.op == MDU_DIVU);
  assign div_zero_c = (bus.b == '0);
  assign commit_c   = busy_q & (cnt_q == CNT_W'(1));
  assign wr_hi_c    = bus.mthi & ~bus.flush & ~busy_q;
  assign wr_lo_c    = bus.mtlo & ~bus.flush & ~busy_q;

  // 64-bit operands keep INT_MIN / -1 well defined; divisor forced to 1 when zero
  assign sa_c      = {{32{bus.a[31]}}, bus.a};
  assign sb_c      = {{32{bus.b[31]}}, bus.b};
  assign ua_c      = {32'd0, bus.a};
  assign ub_c      = {32'd0, bus.b};
  assign sb_safe_c = div_zero_c ? 64'sd1 : sb_c;
  assign ub_safe_c = div_zero_c ? 64'd1  : ub_c;

  // {hi, lo} candidate for the operation presented this cycle
  always_comb begin
    res_c = '0;
    case (bus.op)
      MDU_MULT:  res_c = 64'(sa_c * sb_c);
      MDU_MULTU: res_c = ua_c * ub_c;
      MDU_DIV: begin
        res_c[31:0]  = 32'(sa_c / sb_safe_c);
        res_c[63:32] = 32'(sa_c % sb_safe_c);
      end
      MDU_DIVU: begin
        res_c[31:0]  = 32'(ua_c / ub_safe_c);
        res_c[63:32] = 32'(ua_c % ub_safe_c);
      end
      default: res_c = '0;
    endcase
  end

  // Latency counter and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (accept_c) begin
      cnt_q  <= is_div_c ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (commit_c) busy_q <= 1'b0;
    end
  end

  // Pending result, invisible until commit
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
    end else if (accept_c) begin
      pend_hi_q <= res_c[63:32];
      pend_lo_q <= res_c[31:0];
      pend_ok_q <= ~(is_div_c & div_zero_c);
    end
  end

  // Architectural HI/LO; commit and mthi/mtlo are exclusive because commit needs busy
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit_c) begin
      if (pend_ok_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end else begin
      if (wr_hi_c) hi_q <= bus.a;
      if (wr_lo_c) lo_q <= bus.a;
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
